// File: rtl/player_sprite_src.sv
// -----------------------------------------------------------------------------
// player_sprite_src
//   Per-player sprite source. It maps the current scan position onto an
//   address in the external 2048x3 colour-code RAM and turns the returned code
//   into 12-bit RGB through an 8-entry palette. It overlays that colour on the
//   incoming pixel stream with a fixed 3-cycle latency. It also owns a small
//   write-only register slot for position, control, palette and sprite-RAM
//   writes. Position and control are double-buffered: a write lands in a
//   shadow copy, and the shadow copy is promoted to the active copy on
//   frame_start.
//
// Ports
//   clk, reset            system clock, synchronous active-high reset
//   x, y                  current scan position (11 bits each)
//   frame_start           one-cycle pulse at start of frame
//   wr_en/reg_addr/wr_data  bus write strobe, register select, write data
//   si_rgb / so_rgb       upstream pixel in / composited pixel out
//   ram_addr_r, ram_dout  sprite RAM read port (1-cycle read latency)
//   ram_we, ram_addr_w, ram_din  sprite RAM write port
//
// Optional build macro
//   PLAYER_BLINK_EN       adds ctrl bit2 (blink) and a 5-bit frame counter.
//                         While blink is set, the sprite is hidden on 16 of
//                         every 32 frames.
// -----------------------------------------------------------------------------
module player_sprite_src #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 3,
    parameter int SPR_W      = 32,
    parameter int SPR_H      = 64,
    parameter int KEY_CODE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [10:0]           x,
    input  logic [10:0]           y,
    input  logic                  frame_start,
    input  logic                  wr_en,
    input  logic [2:0]            reg_addr,
    input  logic [31:0]           wr_data,
    input  logic [11:0]           si_rgb,
    output logic [11:0]           so_rgb,
    output logic [ADDR_WIDTH-1:0] ram_addr_r,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr_w,
    output logic [DATA_WIDTH-1:0] ram_din
);

    localparam int XW    = $clog2(SPR_W);
    localparam int YW    = $clog2(SPR_H);
    localparam int PAL_N = 2 ** DATA_WIDTH;

    // ---------------- register decode ----------------
    logic wr_x0, wr_y0, wr_ctrl, wr_pal, wr_ram;
    assign wr_x0   = wr_en && (reg_addr == 3'd0);
    assign wr_y0   = wr_en && (reg_addr == 3'd1);
    assign wr_ctrl = wr_en && (reg_addr == 3'd2);
    assign wr_pal  = wr_en && (reg_addr == 3'd3);
    assign wr_ram  = wr_en && (reg_addr == 3'd4);

    // ---------------- shadow / active position and control ----------------
    logic [10:0] shadow_x0_reg, shadow_y0_reg, active_x0_reg, active_y0_reg;
    logic        shadow_en_reg, shadow_hflip_reg, active_en_reg, active_hflip_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_x0_reg    <= '0;
            shadow_y0_reg    <= '0;
            shadow_en_reg    <= 1'b0;
            shadow_hflip_reg <= 1'b0;
        end else begin
            if (wr_x0)
                shadow_x0_reg <= wr_data[10:0];
            if (wr_y0)
                shadow_y0_reg <= wr_data[10:0];
            if (wr_ctrl) begin
                shadow_en_reg    <= wr_data[0];
                shadow_hflip_reg <= wr_data[1];
            end
        end
    end

    // Nonblocking update means a same-cycle bus write is not yet visible here:
    // the active copy takes the pre-write shadow value.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_x0_reg    <= '0;
            active_y0_reg    <= '0;
            active_en_reg    <= 1'b0;
            active_hflip_reg <= 1'b0;
        end else if (frame_start) begin
            active_x0_reg    <= shadow_x0_reg;
            active_y0_reg    <= shadow_y0_reg;
            active_en_reg    <= shadow_en_reg;
            active_hflip_reg <= shadow_hflip_reg;
        end
    end

    // ---------------- optional blink ----------------
    logic blink_hide;
`ifdef PLAYER_BLINK_EN
    logic       shadow_blink_reg, active_blink_reg;
    logic [4:0] frame_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_blink_reg <= 1'b0;
            active_blink_reg <= 1'b0;
            frame_cnt_reg    <= '0;
        end else begin
            if (wr_ctrl)
                shadow_blink_reg <= wr_data[2];
            if (frame_start) begin
                active_blink_reg <= shadow_blink_reg;
                frame_cnt_reg    <= frame_cnt_reg + 5'd1;
            end
        end
    end

    assign blink_hide = active_blink_reg && frame_cnt_reg[4];
`else
    assign blink_hide = 1'b0;
`endif

    // ---------------- palette (immediate, not double-buffered) ----------------
    logic [11:0] palette_reg [PAL_N];

    generate
        for (genvar gi = 0; gi < PAL_N; gi++) begin : g_pal
            always_ff @(posedge clk) begin
                if (reset)
                    palette_reg[gi] <= '0;
                else if (wr_pal && (wr_data[12 +: DATA_WIDTH] == DATA_WIDTH'(gi)))
                    palette_reg[gi] <= wr_data[11:0];
            end
        end
    endgenerate

    // ---------------- sprite RAM write port ----------------
    logic                  ram_we_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_w_reg;
    logic [DATA_WIDTH-1:0] ram_din_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ram_we_reg     <= 1'b0;
            ram_addr_w_reg <= '0;
            ram_din_reg    <= '0;
        end else begin
            ram_we_reg <= wr_ram;
            if (wr_ram) begin
                ram_addr_w_reg <= wr_data[ADDR_WIDTH+2:3];
                ram_din_reg    <= wr_data[DATA_WIDTH-1:0];
            end
        end
    end

    // ---------------- stage 1: hit test and address ----------------
    // The compares are done at 12 bits, so a sprite near the right edge of
    // the 11-bit range clips instead of wrapping to column 0.
    logic [11:0]           x_ext, y_ext, x0_ext, y0_ext, x_end, y_end;
    logic [10:0]           rel_x, rel_y;
    logic [XW-1:0]         col;
    logic                  hit_next;
    logic [ADDR_WIDTH-1:0] addr_next;

    always_comb begin
        x_ext     = {1'b0, x};
        y_ext     = {1'b0, y};
        x0_ext    = {1'b0, active_x0_reg};
        y0_ext    = {1'b0, active_y0_reg};
        x_end     = x0_ext + 12'(SPR_W);
        y_end     = y0_ext + 12'(SPR_H);
        hit_next  = active_en_reg && !blink_hide
                    && (x_ext >= x0_ext) && (x_ext < x_end)
                    && (y_ext >= y0_ext) && (y_ext < y_end);
        rel_x     = x - active_x0_reg;
        rel_y     = y - active_y0_reg;
        col       = active_hflip_reg ? (XW'(SPR_W - 1) - rel_x[XW-1:0]) : rel_x[XW-1:0];
        addr_next = {rel_y[YW-1:0], col};
    end

    logic                  hit_d1_reg, hit_d2_reg;
    logic [11:0]           si_d1_reg, si_d2_reg, so_rgb_reg;
    logic [ADDR_WIDTH-1:0] ram_addr_r_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_d1_reg     <= 1'b0;
            si_d1_reg      <= '0;
            ram_addr_r_reg <= '0;
            hit_d2_reg     <= 1'b0;
            si_d2_reg      <= '0;
            so_rgb_reg     <= '0;
        end else begin
            // stage 1
            hit_d1_reg     <= hit_next;
            si_d1_reg      <= si_rgb;
            ram_addr_r_reg <= addr_next;
            // stage 2: RAM read in flight
            hit_d2_reg     <= hit_d1_reg;
            si_d2_reg      <= si_d1_reg;
            // stage 3: composite
            if (hit_d2_reg && (ram_dout != DATA_WIDTH'(KEY_CODE)))
                so_rgb_reg <= palette_reg[ram_dout];
            else
                so_rgb_reg <= si_d2_reg;
        end
    end

    assign so_rgb     = so_rgb_reg;
    assign ram_addr_r = ram_addr_r_reg;
    assign ram_we     = ram_we_reg;
    assign ram_addr_w = ram_addr_w_reg;
    assign ram_din    = ram_din_reg;

    // Bits the register map does not use.
    logic unused_bits;
    assign unused_bits = ^{wr_data[31:15], rel_x[10:XW], rel_y[10:YW]};

endmodule

// File: tb/tb_player_sprite_src.sv
// Self-checking bench for player_sprite_src: table-driven pixel vectors whose
// expected outputs are queued when driven and compared when due, plus
// hand-written sequences for double-buffering, RAM writes and reset.
module tb_player_sprite_src;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] x, y;
    logic        frame_start;
    logic        wr_en;
    logic [2:0]  reg_addr;
    logic [31:0] wr_data;
    logic [11:0] si_rgb, so_rgb;
    logic [10:0] ram_addr_r, ram_addr_w;
    logic [2:0]  ram_dout, ram_din;
    logic        ram_we;

    always #5 clk = ~clk;

    player_sprite_src dut (
        .clk(clk), .reset(reset), .x(x), .y(y), .frame_start(frame_start),
        .wr_en(wr_en), .reg_addr(reg_addr), .wr_data(wr_data),
        .si_rgb(si_rgb), .so_rgb(so_rgb),
        .ram_addr_r(ram_addr_r), .ram_dout(ram_dout),
        .ram_we(ram_we), .ram_addr_w(ram_addr_w), .ram_din(ram_din)
    );

    // Sprite colour-code RAM model: registered read, written via DUT port.
    logic [2:0] mem [2048];
    initial for (int i = 0; i < 2048; i++) mem[i] = 3'd0;
    always @(posedge clk) begin
        ram_dout <= mem[ram_addr_r];
        if (ram_we) mem[ram_addr_w] <= ram_din;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] exp;
        string       name;
    } sb_t;

    typedef struct {
        logic [10:0] px;
        logic [10:0] py;
        logic [11:0] si;
        bit          chk_addr;
        logic [10:0] addr;
        logic [11:0] rgb;
        string       name;
    } vec_t;

    sb_t q_rgb[$];
    sb_t q_addr[$];
    int  checks = 0;
    int  passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
            $display("[ok]   %s = 0x%0h", name, act);
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: compare queued expectations on the falling edge when due.
    always @(negedge clk) begin
        while (q_rgb.size() > 0 && q_rgb[0].due == cyc) begin
            sb_t e;
            e = q_rgb.pop_front();
            check(e.name, 32'(so_rgb), e.exp);
        end
        while (q_addr.size() > 0 && q_addr[0].due == cyc) begin
            sb_t e;
            e = q_addr.pop_front();
            check(e.name, 32'(ram_addr_r), e.exp);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [10:0] px, input logic [10:0] py, input logic [11:0] si,
                       input bit chk_addr, input logic [10:0] addr, input logic [11:0] rgb,
                       input string name);
        x = px;
        y = py;
        si_rgb = si;
        q_rgb.push_back('{cyc + 3, 32'(rgb), name});
        if (chk_addr) q_addr.push_back('{cyc + 1, 32'(addr), {name, "_addr"}});
        tick();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        reg_addr = a;
        wr_data  = d;
        wr_en    = 1'b1;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic pulse_fs();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic drain();
        repeat (4) tick();
    endtask

    vec_t tbl [8];

    initial begin
        // x0=100, y0=50, enable=1, hflip=0; mem[0]=5, mem[31]=3
        tbl[0] = '{11'd100, 11'd50,  12'h123, 1'b1, 11'd0,    12'hF00, "hit_origin"};
        tbl[1] = '{11'd99,  11'd50,  12'h111, 1'b0, 11'd0,    12'h111, "left_of_sprite"};
        tbl[2] = '{11'd132, 11'd50,  12'h222, 1'b0, 11'd0,    12'h222, "right_of_sprite"};
        tbl[3] = '{11'd131, 11'd50,  12'h333, 1'b1, 11'd31,   12'h0F0, "last_column"};
        tbl[4] = '{11'd100, 11'd49,  12'h444, 1'b0, 11'd0,    12'h444, "above_sprite"};
        tbl[5] = '{11'd100, 11'd114, 12'h555, 1'b0, 11'd0,    12'h555, "below_sprite"};
        tbl[6] = '{11'd100, 11'd113, 12'h666, 1'b1, 11'd2016, 12'h666, "last_row_key"};
        tbl[7] = '{11'd101, 11'd50,  12'h777, 1'b1, 11'd1,    12'h777, "key_code_col1"};

        reset = 1'b1; x = '0; y = '0; frame_start = 1'b0;
        wr_en = 1'b0; reg_addr = '0; wr_data = '0; si_rgb = 12'hABC;
        repeat (3) tick();
        check("rst_so_rgb",     32'(so_rgb),     32'h0);
        check("rst_ram_addr_r", 32'(ram_addr_r), 32'h0);
        check("rst_ram_we",     32'(ram_we),     32'h0);
        check("rst_ram_addr_w", 32'(ram_addr_w), 32'h0);
        check("rst_ram_din",    32'(ram_din),    32'h0);
        reset = 1'b0;

        // Passthrough with enable=0
        for (int i = 0; i < 6; i++)
            pix(11'(i * 7), 11'd10, 12'hABC, 1'b0, 11'd0, 12'hABC, "passthrough_disabled");
        drain();

        // Main setup
        bus_write(3'd0, 32'd100);
        bus_write(3'd1, 32'd50);
        bus_write(3'd2, 32'd1);
        bus_write(3'd3, (32'd5 << 12) | 32'hF00);
        bus_write(3'd3, (32'd3 << 12) | 32'h0F0);
        bus_write(3'd3, (32'd6 << 12) | 32'h00F);
        bus_write(3'd4, (32'd0  << 3) | 32'd5);
        bus_write(3'd4, (32'd31 << 3) | 32'd3);
        bus_write(3'd4, (32'd19 << 3) | 32'd6);
        pulse_fs();

        for (int i = 0; i < 8; i++)
            pix(tbl[i].px, tbl[i].py, tbl[i].si, tbl[i].chk_addr, tbl[i].addr, tbl[i].rgb, tbl[i].name);
        drain();

        // hflip: shadow-only until frame_start
        bus_write(3'd2, 32'd3);
        pix(11'd100, 11'd50, 12'h901, 1'b1, 11'd0, 12'hF00, "hflip_shadow_only");
        drain();
        pulse_fs();
        pix(11'd100, 11'd50, 12'h902, 1'b1, 11'd31, 12'h0F0, "hflip_col0");
        pix(11'd131, 11'd50, 12'h903, 1'b1, 11'd0,  12'hF00, "hflip_col31");
        drain();

        // Key code at a hit pixel
        bus_write(3'd4, 32'd0);
        pix(11'd131, 11'd50, 12'h904, 1'b1, 11'd0, 12'h904, "key_code_hit");
        drain();
        bus_write(3'd4, 32'd5);
        bus_write(3'd2, 32'd1);
        pulse_fs();

        // Double-buffered x0
        bus_write(3'd0, 32'd200);
        pix(11'd100, 11'd50, 12'h911, 1'b1, 11'd0, 12'hF00, "x0_write_no_fs");
        pix(11'd200, 11'd50, 12'h912, 1'b0, 11'd0, 12'h912, "x0_shadow_not_active");
        drain();
        bus_write(3'd0, 32'd100);
        reg_addr = 3'd0; wr_data = 32'd200; wr_en = 1'b1; frame_start = 1'b1;
        tick();
        wr_en = 1'b0; frame_start = 1'b0;
        pix(11'd100, 11'd50, 12'h913, 1'b1, 11'd0, 12'hF00, "fs_same_cycle_old_x0");
        pix(11'd200, 11'd50, 12'h914, 1'b0, 11'd0, 12'h914, "fs_same_cycle_new_pass");
        drain();
        pulse_fs();
        pix(11'd200, 11'd50, 12'h915, 1'b1, 11'd0, 12'hF00, "next_fs_new_x0");
        pix(11'd100, 11'd50, 12'h916, 1'b0, 11'd0, 12'h916, "next_fs_old_pass");
        drain();

        // Partly off-screen and far-right sprites: no wrap to the left
        bus_write(3'd0, 32'd620);
        pulse_fs();
        pix(11'd639, 11'd50, 12'h921, 1'b1, 11'd19, 12'h00F, "offscreen_visible");
        pix(11'd0,   11'd50, 12'h922, 1'b0, 11'd0,  12'h922, "offscreen_no_wrap");
        drain();
        bus_write(3'd0, 32'd2047);
        pulse_fs();
        pix(11'd0,   11'd50, 12'h931, 1'b0, 11'd0, 12'h931, "x0_max_col0");
        pix(11'd30,  11'd50, 12'h932, 1'b0, 11'd0, 12'h932, "x0_max_col30");
        pix(11'd639, 11'd50, 12'h933, 1'b0, 11'd0, 12'h933, "x0_max_col639");
        drain();
        bus_write(3'd0, 32'd100);
        pulse_fs();

        // Sprite RAM write strobe and ignored registers
        bus_write(3'd4, (32'd7 << 3) | 32'd3);
        check("reg4_ram_we",     32'(ram_we),     32'd1);
        check("reg4_ram_addr_w", 32'(ram_addr_w), 32'd7);
        check("reg4_ram_din",    32'(ram_din),    32'd3);
        tick();
        check("reg4_ram_we_drop", 32'(ram_we), 32'd0);
        bus_write(3'd5, 32'hFFFF_FFFF);
        check("reg5_ram_we", 32'(ram_we), 32'd0);
        bus_write(3'd7, 32'hFFFF_FFFF);
        tick();
        check("reg7_ram_we",     32'(ram_we),     32'd0);
        check("reg5_ram_addr_w", 32'(ram_addr_w), 32'd7);
        check("reg5_ram_din",    32'(ram_din),    32'd3);
        pulse_fs();
        pix(11'd100, 11'd50, 12'h941, 1'b1, 11'd0, 12'hF00, "reg5_no_side_effect");
        pix(11'd107, 11'd50, 12'h942, 1'b1, 11'd7, 12'h0F0, "ram_write_readback");
        drain();

        // Reset mid-frame on a hit pixel
        x = 11'd100; y = 11'd50; si_rgb = 12'h951;
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_so_rgb", 32'(so_rgb), 32'h0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++)
            pix(11'd100, 11'd50, 12'hABC, 1'b0, 11'd0, 12'hABC, "post_reset_passthrough");
        drain();

        // Bounded wait for outstanding expectations
        for (int i = 0; i < 10 && (q_rgb.size() + q_addr.size()) > 0; i++) tick();
        if ((q_rgb.size() + q_addr.size()) > 0) begin
            checks++;
            $display("FAIL scoreboard_drain: got %0d pending entries, expected 0",
                     q_rgb.size() + q_addr.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
